// File: rtl/color_counter_if.sv
// color_counter_if
//   Result bus between the color counter and its consumer (LCD controller).
//   Signals:
//     clear       - synchronous count clear, driven by the consumer
//     count       - objects counted (feeds contador_externo)
//     color       - latest classification: 0 red, 1 green, 2 blue, 3 none
//     color_valid - one-cycle strobe when color updates
//     last_color  - color of the most recently counted object
//     fsm_state   - measurement FSM state (0 settle, 1 gate, 2 classify)
//   Handshake: color_valid is a single-cycle strobe with no ready/backpressure;
//   the consumer must sample color in the cycle color_valid is high, and
//   color stays stable until the next strobe.
interface color_counter_if;
   logic       clear;
   logic [9:0] count;
   logic [1:0] color;
   logic       color_valid;
   logic [1:0] last_color;
   logic [1:0] fsm_state;

   modport master (
      input  clear,
      output count, color, color_valid, last_color, fsm_state
   );

   modport slave (
      output clear,
      input  count, color, color_valid, last_color, fsm_state
   );
endinterface

// File: rtl/color_counter.sv
// color_counter
//   Drives a TCS3200 color sensor through its red/green/blue filters,
//   measures the output frequency for each filter, classifies the dominant
//   color, and counts objects reported by a debounced IR presence sensor.
//   Each object is counted once, when the first valid classification
//   arrives while it is present.
//   Ports:
//     clk        - system clock
//     rst        - asynchronous active-high reset
//     sensor_out - asynchronous TCS3200 frequency output
//     obj_sense  - asynchronous IR object-presence input, active-high
//     s2, s3     - TCS3200 filter select
//     bus        - result bus (clear in; count/color/color_valid/last_color/
//                  fsm_state out)
module color_counter #(
   parameter int unsigned SETTLE_CYCLES   = 5_000,
   parameter int unsigned GATE_CYCLES     = 500_000,
   parameter int unsigned MIN_EDGES       = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 500_000,
   parameter int unsigned COUNT_MAX       = 999
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sensor_out,
   input  logic              obj_sense,
   output logic              s2,
   output logic              s3,
   color_counter_if.master   bus
);

   typedef enum logic [1:0] {
      ST_SETTLE   = 2'd0,
      ST_GATE     = 2'd1,
      ST_CLASSIFY = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      F_RED   = 2'd0,
      F_GREEN = 2'd1,
      F_BLUE  = 2'd2
   } filt_t;

   localparam int unsigned TMAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
   localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   // ------------------------------------------------------------------
   // Input synchronizers
   // ------------------------------------------------------------------
   logic [1:0] sens_sync;
   logic [1:0] obj_sync;
   logic       sens_prev;
   logic       sens_rise;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sens_sync <= 2'b00;
         obj_sync  <= 2'b00;
         sens_prev <= 1'b0;
      end else begin
         sens_sync <= {sens_sync[0], sensor_out};
         obj_sync  <= {obj_sync[0], obj_sense};
         sens_prev <= sens_sync[1];
      end
   end

   assign sens_rise = sens_sync[1] & ~sens_prev;

   // ------------------------------------------------------------------
   // Measurement FSM: SETTLE -> GATE per filter, CLASSIFY after blue
   // ------------------------------------------------------------------
   state_t         state, state_nx;
   filt_t          filt, filt_nx;
   logic [TW-1:0]  timer, timer_nx;
   logic           gate_start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_SETTLE;
         filt  <= F_RED;
         timer <= '0;
      end else begin
         state <= state_nx;
         filt  <= filt_nx;
         timer <= timer_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      filt_nx    = filt;
      timer_nx   = timer + 1'b1;
      gate_start = 1'b0;
      case (state)
         ST_SETTLE: begin
            if (timer == TW'(SETTLE_CYCLES - 1)) begin
               state_nx   = ST_GATE;
               timer_nx   = '0;
               gate_start = 1'b1;
            end
         end
         ST_GATE: begin
            if (timer == TW'(GATE_CYCLES - 1)) begin
               timer_nx = '0;
               if (filt == F_BLUE) begin
                  state_nx = ST_CLASSIFY;
               end else begin
                  state_nx = ST_SETTLE;
                  filt_nx  = (filt == F_RED) ? F_GREEN : F_BLUE;
               end
            end
         end
         ST_CLASSIFY: begin
            state_nx = ST_SETTLE;
            filt_nx  = F_RED;
            timer_nx = '0;
         end
         default: begin
            state_nx = ST_SETTLE;
            filt_nx  = F_RED;
            timer_nx = '0;
         end
      endcase
   end

   // Filter select straight from the reset-cleared filter register, so the
   // pins fall to red (00) asynchronously with rst. CLASSIFY keeps blue.
   always_comb begin
      s2 = 1'b0;
      s3 = 1'b0;
      case (filt)
         F_GREEN: begin s2 = 1'b1; s3 = 1'b1; end
         F_BLUE:  begin s2 = 1'b0; s3 = 1'b1; end
         default: begin s2 = 1'b0; s3 = 1'b0; end
      endcase
   end

   // ------------------------------------------------------------------
   // Edge counters: cleared when their GATE starts, saturate at 65535
   // ------------------------------------------------------------------
   logic [15:0] cnt_r, cnt_g, cnt_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
         cnt_g <= '0;
         cnt_b <= '0;
      end else if (gate_start) begin
         case (filt)
            F_RED:   cnt_r <= '0;
            F_GREEN: cnt_g <= '0;
            default: cnt_b <= '0;
         endcase
      end else if (state == ST_GATE && sens_rise) begin
         case (filt)
            F_RED:   if (cnt_r != 16'hFFFF) cnt_r <= cnt_r + 16'd1;
            F_GREEN: if (cnt_g != 16'hFFFF) cnt_g <= cnt_g + 16'd1;
            default: if (cnt_b != 16'hFFFF) cnt_b <= cnt_b + 16'd1;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Classification: largest count wins, ties go red > green > blue
   // ------------------------------------------------------------------
   logic [15:0] win_cnt;
   logic [1:0]  win_col;
   logic [1:0]  class_color;

   always_comb begin
      win_cnt = cnt_b;
      win_col = 2'd2;
      if (cnt_r >= cnt_g && cnt_r >= cnt_b) begin
         win_cnt = cnt_r;
         win_col = 2'd0;
      end else if (cnt_g >= cnt_b) begin
         win_cnt = cnt_g;
         win_col = 2'd1;
      end
      class_color = (win_cnt < 16'(MIN_EDGES)) ? 2'd3 : win_col;
   end

   logic [1:0] color_r;
   logic       color_valid_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         color_r       <= 2'd3;
         color_valid_r <= 1'b0;
      end else begin
         color_valid_r <= (state == ST_CLASSIFY);
         if (state == ST_CLASSIFY) color_r <= class_color;
      end
   end

   // ------------------------------------------------------------------
   // Object-presence debouncer: level must differ from the debounced state
   // for DEBOUNCE_CYCLES consecutive clocks before it is accepted.
   // ------------------------------------------------------------------
   logic          deb;
   logic [DW-1:0] deb_cnt;
   logic          deb_flip;
   logic          deb_rise;
   logic          deb_fall;

   assign deb_flip = (obj_sync[1] != deb) && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb      <= 1'b0;
         deb_cnt  <= '0;
         deb_rise <= 1'b0;
         deb_fall <= 1'b0;
      end else begin
         deb_rise <= deb_flip & obj_sync[1];
         deb_fall <= deb_flip & ~obj_sync[1];
         if (obj_sync[1] == deb) begin
            deb_cnt <= '0;
         end else if (deb_flip) begin
            deb     <= obj_sync[1];
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Object counting. pending marks an object present but not yet counted;
   // consuming it on a valid color guarantees one count per presence.
   // ------------------------------------------------------------------
   logic [9:0] count_r;
   logic [1:0] last_color_r;
   logic       pending;
   logic       count_evt;

   assign count_evt = color_valid_r & pending & (color_r != 2'd3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r      <= '0;
         last_color_r <= 2'd3;
         pending      <= 1'b0;
      end else if (bus.clear) begin
         count_r      <= '0;
         last_color_r <= 2'd3;
         pending      <= 1'b0;
      end else if (count_evt) begin
         count_r      <= (count_r == 10'(COUNT_MAX)) ? 10'd0 : count_r + 10'd1;
         last_color_r <= color_r;
         pending      <= 1'b0;
      end else if (deb_rise) begin
         pending <= 1'b1;
      end else if (deb_fall) begin
         pending <= 1'b0;
      end
   end

   assign bus.count       = count_r;
   assign bus.color       = color_r;
   assign bus.color_valid = color_valid_r;
   assign bus.last_color  = last_color_r;
   assign bus.fsm_state   = state;

endmodule

// File: tb/tb_color_counter.sv
// tb_color_counter
//   Directed bench for color_counter with short timing parameters
//   (settle 10, gate 100, min edges 4, debounce 4, count max 3).
//   One measurement sequence is 3*(10+100)+1 = 331 clocks.
module tb_color_counter;

   logic clk;
   logic rst;
   logic sensor_out;
   logic obj_sense;
   logic s2;
   logic s3;

   color_counter_if cif();

   color_counter #(
      .SETTLE_CYCLES  (10),
      .GATE_CYCLES    (100),
      .MIN_EDGES      (4),
      .DEBOUNCE_CYCLES(4),
      .COUNT_MAX      (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sensor_out(sensor_out),
      .obj_sense (obj_sense),
      .s2        (s2),
      .s3        (s3),
      .bus       (cif.master)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // sensor half-period pattern per filter (0 = static low)
   int per_r = 0;
   int per_g = 0;
   int per_b = 0;
   int tick  = 0;

   logic [1:0] filt_q[$];
   logic [1:0] last_f;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- sensor driver ----------------
   initial begin
      sensor_out = 1'b0;
      forever begin
         int per;
         @(negedge clk);
         tick++;
         case ({s2, s3})
            2'b00:   per = per_r;
            2'b11:   per = per_g;
            default: per = per_b;
         endcase
         sensor_out = (per == 0) ? 1'b0 : ((tick % per) < (per / 2));
      end
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      obj_sense = 1'b0;
      cif.clear = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   // Returns the number of clocks until color_valid is seen high; also logs
   // every change of the filter select pins.
   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if ({s2, s3} != last_f) begin
            filt_q.push_back({s2, s3});
            last_f = {s2, s3};
         end
      end while (!cif.color_valid && n < 1000);
      if (!cif.color_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL valid_timeout got=%0d exp<1000", n);
      end
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int n;
      rst       = 1'b1;
      obj_sense = 1'b0;
      cif.clear = 1'b0;
      last_f    = 2'b00;

      // Test 1: red dominant, sequence timing, filter order, reset values
      per_r = 10; per_g = 25; per_b = 25;
      do_reset();
      #1;
      check_eq("rst_count",      32'(cif.count),       0);
      check_eq("rst_color",      32'(cif.color),       3);
      check_eq("rst_valid",      32'(cif.color_valid), 0);
      check_eq("rst_last_color", 32'(cif.last_color),  3);
      check_eq("rst_s2s3",       32'({s2, s3}),        0);
      check_eq("rst_fsm_state",  32'(cif.fsm_state),   0);
      filt_q.delete();
      last_f = 2'b00;
      wait_valid(n);
      check_eq("t1_first_valid_lat", 32'(n), 331);
      check_eq("t1_color_red",       32'(cif.color), 0);
      step(1);
      check_eq("t1_valid_one_cycle", 32'(cif.color_valid), 0);
      wait_valid(n);
      check_eq("t1_valid_period", 32'(n), 330);
      check_eq("t1_filt_changes", 32'(filt_q.size()), 6);
      if (filt_q.size() >= 3) begin
         check_eq("t1_filt0_green", 32'(filt_q[0]), 3);
         check_eq("t1_filt1_blue",  32'(filt_q[1]), 1);
         check_eq("t1_filt2_red",   32'(filt_q[2]), 0);
      end

      // Test 2: sensor static low -> no color, nothing counted
      per_r = 0; per_g = 0; per_b = 0;
      do_reset();
      obj_sense = 1'b1;
      wait_valid(n);
      check_eq("t2_color_none", 32'(cif.color), 3);
      step(1);
      check_eq("t2_count_0a", 32'(cif.count), 0);
      wait_valid(n);
      step(1);
      check_eq("t2_count_0b", 32'(cif.count), 0);

      // Test 3: glitch ignored, green object counted exactly once
      per_r = 25; per_g = 10; per_b = 25;
      do_reset();
      step(5);
      obj_sense = 1'b1;
      step(2);
      obj_sense = 1'b0;
      wait_valid(n);
      check_eq("t3_color_green", 32'(cif.color), 1);
      step(1);
      check_eq("t3_glitch_no_count", 32'(cif.count), 0);
      obj_sense = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_valid(n);
         step(1);
         check_eq("t3_count_once", 32'(cif.count), 1);
         check_eq("t3_last_green", 32'(cif.last_color), 1);
      end
      obj_sense = 1'b0;

      // Test 4: four blue objects, count wraps 3 -> 0
      per_r = 25; per_g = 25; per_b = 10;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         obj_sense = 1'b1;
         wait_valid(n);
         check_eq("t4_color_blue", 32'(cif.color), 2);
         step(1);
         check_eq("t4_count", 32'(cif.count), 32'((i + 1) % 4));
         check_eq("t4_last_blue", 32'(cif.last_color), 2);
         obj_sense = 1'b0;
         step(20);
      end

      // Test 5: clear coincident with a counting color_valid
      per_r = 10; per_g = 25; per_b = 25;
      do_reset();
      obj_sense = 1'b1;
      wait_valid(n);
      step(1);
      check_eq("t5_count_pre", 32'(cif.count), 1);
      check_eq("t5_last_red",  32'(cif.last_color), 0);
      obj_sense = 1'b0;
      step(20);
      obj_sense = 1'b1;
      wait_valid(n);
      cif.clear = 1'b1;
      step(1);
      cif.clear = 1'b0;
      check_eq("t5_clear_count", 32'(cif.count), 0);
      check_eq("t5_clear_last",  32'(cif.last_color), 3);
      wait_valid(n);
      step(1);
      check_eq("t5_pending_cleared", 32'(cif.count), 0);
      obj_sense = 1'b0;

      // Test 6: reset in the middle of the blue gate
      do_reset();
      obj_sense = 1'b1;
      wait_valid(n);
      step(1);
      check_eq("t6_count_pre", 32'(cif.count), 1);
      step(278);
      check_eq("t6_in_blue",      32'({s2, s3}), 1);
      check_eq("t6_in_gate",      32'(cif.fsm_state), 1);
      rst = 1'b1;
      #1;
      check_eq("t6_rst_count",    32'(cif.count), 0);
      check_eq("t6_rst_color",    32'(cif.color), 3);
      check_eq("t6_rst_valid",    32'(cif.color_valid), 0);
      check_eq("t6_rst_last",     32'(cif.last_color), 3);
      check_eq("t6_rst_s2s3",     32'({s2, s3}), 0);
      check_eq("t6_rst_fsm",      32'(cif.fsm_state), 0);
      @(negedge clk);
      rst = 1'b0;
      obj_sense = 1'b0;
      last_f = {s2, s3};
      step(1);
      check_eq("t6_post_s2s3", 32'({s2, s3}), 0);
      wait_valid(n);
      check_eq("t6_restart_lat", 32'(n), 330);
      check_eq("t6_color_red",   32'(cif.color), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/color_counter.md
COLOR_COUNTER -- requirements
Module: color_counter

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 5_000, meaning clocks waited after each filter change before gating.
REQ-002 SHALL have parameter GATE_CYCLES, default 500_000, meaning clocks per frequency-measurement window.
REQ-003 SHALL have parameter MIN_EDGES, default 16, meaning minimum winning edge count for a valid color.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 500_000, meaning clocks obj_sense must be stable to change debounced state.
REQ-005 SHALL have parameter COUNT_MAX, default 999, meaning last count value before wrap to 0.
REQ-006 SHALL have port clk, input, 1, system clock; reset rst, asynchronous, active-high; clock clk.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port sensor_out, input, 1, asynchronous TCS3200 frequency output.
REQ-009 SHALL have port obj_sense, input, 1, asynchronous IR object-presence signal, active-high.
REQ-010 SHALL have port clear, input, 1, synchronous count clear.
REQ-011 SHALL have ports s2 and s3, output, 1 each, TCS3200 filter select.
REQ-012 SHALL have port count, output, 10, objects counted, feeds LCD controller contador_externo.
REQ-013 SHALL have port color, output, 2, latest classification: 0 red, 1 green, 2 blue, 3 none.
REQ-014 SHALL have port color_valid, output, 1, one-cycle pulse when color updates.
REQ-015 SHALL have port last_color, output, 2, color of most recently counted object.

Function
REQ-016 SHALL pass sensor_out and obj_sense through two-flop synchronizers before any use.
REQ-017 SHALL sequence filters red (s2=0,s3=0), green (s2=1,s3=1), blue (s2=0,s3=1), repeating forever.
REQ-018 SHALL, per filter, hold states SETTLE for SETTLE_CYCLES clocks then GATE for GATE_CYCLES clocks, counting synchronized sensor_out rising edges only during GATE.
REQ-019 SHALL use 16-bit edge counters saturating at 65535, cleared on entry to each GATE.
REQ-020 SHALL enter CLASSIFY for exactly one cycle after the last blue GATE cycle, then return to red SETTLE.
REQ-021 SHALL in CLASSIFY select the largest of red/green/blue counts, ties resolved red over green over blue.
REQ-022 SHALL report color=3 when the winning count is below MIN_EDGES.
REQ-023 SHALL register color and pulse color_valid high in the cycle after CLASSIFY; color holds until next update.
REQ-024 SHALL debounce synchronized obj_sense: debounced state changes only after DEBOUNCE_CYCLES consecutive clocks at the new level.
REQ-025 SHALL set a pending flag on debounced rising edge; clear pending on debounced falling edge.
REQ-026 SHALL, on color_valid with pending=1 and color!=3, increment count, load last_color=color, clear pending.
REQ-027 SHALL leave pending set and count unchanged on color_valid with color=3.
REQ-028 SHALL count each object at most once per debounced high period.
REQ-029 SHALL wrap count from COUNT_MAX to 0 on increment.
REQ-030 SHALL give clear priority over a simultaneous increment: count=0, last_color=3, pending cleared.

Reset
REQ-031 SHALL on rst asynchronously force s2=0, s3=0, count=0, color=3, color_valid=0, last_color=3.
REQ-032 SHALL on rst clear edge counters, timers, debouncer, pending flag, and return FSM to red SETTLE.
REQ-033 SHALL after rst mid-measurement discard partial results and restart from red SETTLE.

Verification (SETTLE_CYCLES=10, GATE_CYCLES=100, MIN_EDGES=4, DEBOUNCE_CYCLES=4, COUNT_MAX=3)
REQ-034 SHALL verify: sensor_out period 10 clk under red, 25 clk under green/blue -> color=0, color_valid pulse once per 331-cycle sequence, s2/s3 sequence 00,11,01.
REQ-035 SHALL verify: sensor_out static low -> color=3, count stays 0 with obj_sense high.
REQ-036 SHALL verify: obj_sense high 3 sequences with green dominant -> count 0->1 exactly once, last_color=1; obj_sense 2-clk glitch -> no count.
REQ-037 SHALL verify: four objects with blue dominant -> count 1,2,3,0, last_color=2.
REQ-038 SHALL verify: clear asserted in same cycle as counting color_valid -> count=0, last_color=3.
REQ-039 SHALL verify: rst pulsed mid blue GATE -> all outputs at reset values immediately, next s2/s3=00, no color_valid until full new sequence.
